seg7_mux_decoder: RTL and testbench
===================================

# seg7_mux_decoder

Receive-side companion to the team's multiplexed 7-segment display drivers. Samples active-low segment and anode lines of a 3-digit time-multiplexed display, filters scan glitches, decodes each digit pattern back to BCD and assembles complete frames. Each complete frame is reported as BCD plus binary value with a one-cycle strobe. Used for on-chip self-check and loopback of display outputs.

## Interface
- STABLE_CYCLES, 16: cycles a synchronized pattern must hold unchanged before it is accepted; legal range 4..255.
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- seg_n  in  7  segment lines, active-low, bit0=a … bit6=g; asynchronous to clk
- an_n  in  4  anode selects, active-low; 1110=units, 1101=tens, 1011=hundreds, 1111=blank
- digits  out  12  last frame BCD {hundreds, tens, units}
- value  out  10  last frame binary value, 0..999
- valid  out  1  one-cycle strobe: digits/value/err updated
- err  out  1  last frame contained an undecodable segment pattern

## Operation
- Input path: two-flop synchronizer on {an_n, seg_n} (11 bits), then a registered copy `prev`.
- Stability filter: counter `stab` clears when the synchronized word differs from `prev`; otherwise increments, saturating at STABLE_CYCLES. A pattern is qualified on the cycle `stab` reaches STABLE_CYCLES-1. Each pattern qualifies at most once.
- Segment decode, codes 40,79,24,30,19,12,02,78,00,10 (hex) → 0..9. Any other code → digit 4'hF, bad flag set.
- Qualified units/tens/hundreds pattern: the decoded digit is written to its slot, the slot bit is set in `mask[2:0]`, and the bad flag is ORed into `frame_bad`. A repeated slot in the same frame overwrites; last wins.
- Qualified illegal anode pattern (not one of the four listed): frame discarded; mask and frame_bad cleared.
- Qualified blank, mask==111: snapshot slots and frame_bad into the conversion registers, clear mask/frame_bad, FSM IDLE→CONV.
- Qualified blank, mask!=111: frame dropped silently; mask and frame_bad cleared.
- FSM states:
  - IDLE
  - CONV: compute hundreds*100 + tens*10 + units, treating 4'hF as 0.
  - OUT: register digits/value/err, pulse valid; → IDLE.
- Width rule: products computed at 10 bits, with no truncation for 0..999.

## Timing
- Reset values: digits=0, value=0, valid=0, err=0, mask=0, stab=0, FSM=IDLE, synchronizers=all ones.
- Pin-to-qualify latency: 2 sync cycles + STABLE_CYCLES cycles.
- Valid is asserted 2 cycles after blank qualification (CONV, then OUT).
- Outputs hold until the next valid.
- Captures arriving during CONV/OUT go to the next frame; the conversion uses snapshot registers only.
- Next blank qualification cannot overlap conversion, since STABLE_CYCLES ≥ 4.
- Reset asserted mid-frame or mid-conversion aborts everything; no valid is emitted for the aborted frame.

## Configuration
- SEG7_DEC_DEDUP_EN defined: OUT asserts valid only if {digits, err} of the new frame differ from the registered outputs. Output registers are updated only in that case. The first frame after reset always reports.
- Undefined: every complete frame produces valid.

## Structure
- Shared package seg7_pkg holds:
  - segment code constants SEG_0..SEG_9 and SEG_BLANK (7F)
  - anode constants AN_UNITS, AN_TENS, AN_HUNDS, AN_OFF
  - the FSM state enum
  - BCD_INVALID (4'hF)
- Sub-module seg7_pattern_decode: combinational, 7-bit code → {bad, digit[3:0]}; shareable with other display-loopback blocks.

## Test plan
- STABLE_CYCLES=16, each phase held 64 cycles:
  - units 78, tens 19, hundreds 24, then blank → one valid; digits=0x247, value=247, err=0.
  - Same frame, but tens phase preceded by a 3-cycle 00/1101 glitch → result identical (0x247); glitch never captured.
  - Tens code 7F → valid with err=1, digits=0x2F7, value=207.
  - Hundreds phase omitted before blank → no valid. Next full frame 0/0/5 → digits=0x005, value=5.
- Anode 1100 held stable mid-frame, then remaining slots and blank → no valid for that frame.
- Frame 0x128 sent twice: 2 valids without SEG7_DEC_DEDUP_EN, 1 with it. rst_n pulsed mid-second-frame → no valid, outputs=0.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants, FSM state type and helpers for 7-segment display loopback blocks.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [3:0] AN_UNITS = 4'b1110;
  localparam logic [3:0] AN_TENS  = 4'b1101;
  localparam logic [3:0] AN_HUNDS = 4'b1011;
  localparam logic [3:0] AN_OFF   = 4'b1111;

  localparam logic [3:0] BCD_INVALID = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONV,
    ST_OUT
  } state_e;

  // Undecodable digits contribute zero to the binary value.
  function automatic logic [9:0] bcd_weight(input logic [3:0] d);
    return (d == BCD_INVALID) ? 10'd0 : {6'd0, d};
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational active-low 7-segment code to BCD digit decoder with illegal-code flag.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] code_i,
  output logic [3:0] digit_o,
  output logic       bad_o
);

  always_comb begin
    digit_o = BCD_INVALID;
    bad_o   = 1'b0;
    case (code_i)
      SEG_0:   digit_o = 4'd0;
      SEG_1:   digit_o = 4'd1;
      SEG_2:   digit_o = 4'd2;
      SEG_3:   digit_o = 4'd3;
      SEG_4:   digit_o = 4'd4;
      SEG_5:   digit_o = 4'd5;
      SEG_6:   digit_o = 4'd6;
      SEG_7:   digit_o = 4'd7;
      SEG_8:   digit_o = 4'd8;
      SEG_9:   digit_o = 4'd9;
      default: bad_o   = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_mux_decoder.sv
// Samples a 3-digit multiplexed 7-segment display, filters glitches and reports whole frames.
// Optional macro SEG7_DEC_DEDUP_EN: report only frames whose {digits, err} changed.
module seg7_mux_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg_n,
  input  logic [3:0]  an_n,
  output logic [11:0] digits,
  output logic [9:0]  value,
  output logic        valid,
  output logic        err
);

  localparam logic [7:0] STAB_MAX = 8'(STABLE_CYCLES);

  logic [10:0] sync1_q, sync2_q, prev_q;
  logic [7:0]  stab_q;
  logic        qual;
  logic [3:0]  dec_digit;
  logic        dec_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
      prev_q  <= '1;
      stab_q  <= '0;
    end else begin
      sync1_q <= {an_n, seg_n};
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      if (sync2_q != prev_q)
        stab_q <= '0;
      else if (stab_q != STAB_MAX)
        stab_q <= stab_q + 8'd1;
    end
  end

  // Saturation at STAB_MAX keeps a held pattern from qualifying twice.
  assign qual = (sync2_q == prev_q) && (stab_q == STAB_MAX - 8'd1);

  seg7_pattern_decode u_decode (
    .code_i  (prev_q[6:0]),
    .digit_o (dec_digit),
    .bad_o   (dec_bad)
  );

  logic [3:0] units_q, tens_q, hunds_q;
  logic [2:0] mask_q;
  logic       frame_bad_q;
  logic [3:0] conv_u_q, conv_t_q, conv_h_q;
  logic       conv_bad_q;
  logic       snap;

  assign snap = qual && (prev_q[10:7] == AN_OFF) && (mask_q == 3'b111);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      units_q     <= '0;
      tens_q      <= '0;
      hunds_q     <= '0;
      mask_q      <= '0;
      frame_bad_q <= 1'b0;
      conv_u_q    <= '0;
      conv_t_q    <= '0;
      conv_h_q    <= '0;
      conv_bad_q  <= 1'b0;
    end else if (qual) begin
      case (prev_q[10:7])
        AN_UNITS: begin
          units_q     <= dec_digit;
          mask_q[0]   <= 1'b1;
          frame_bad_q <= frame_bad_q | dec_bad;
        end
        AN_TENS: begin
          tens_q      <= dec_digit;
          mask_q[1]   <= 1'b1;
          frame_bad_q <= frame_bad_q | dec_bad;
        end
        AN_HUNDS: begin
          hunds_q     <= dec_digit;
          mask_q[2]   <= 1'b1;
          frame_bad_q <= frame_bad_q | dec_bad;
        end
        AN_OFF: begin
          if (mask_q == 3'b111) begin
            conv_u_q   <= units_q;
            conv_t_q   <= tens_q;
            conv_h_q   <= hunds_q;
            conv_bad_q <= frame_bad_q;
          end
          mask_q      <= '0;
          frame_bad_q <= 1'b0;
        end
        default: begin
          mask_q      <= '0;
          frame_bad_q <= 1'b0;
        end
      endcase
    end
  end

  state_e     state_q, state_d;
  logic [9:0] conv_value;
  logic       report;
  logic       load_out;

  assign conv_value = bcd_weight(conv_h_q) * 10'd100
                    + bcd_weight(conv_t_q) * 10'd10
                    + bcd_weight(conv_u_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (snap) state_d = ST_CONV;
      ST_CONV: state_d = ST_OUT;
      ST_OUT:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef SEG7_DEC_DEDUP_EN
  logic first_q;

  assign report = first_q || ({conv_h_q, conv_t_q, conv_u_q, conv_bad_q} != {digits, err});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        first_q <= 1'b1;
    else if (load_out) first_q <= 1'b0;
  end
`else
  assign report = 1'b1;
`endif

  // Output registers load on the CONV->OUT edge so valid is high while in OUT.
  always_comb begin
    load_out = 1'b0;
    if (state_q == ST_CONV) load_out = report;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits <= '0;
      value  <= '0;
      err    <= 1'b0;
      valid  <= 1'b0;
    end else begin
      valid <= load_out;
      if (load_out) begin
        digits <= {conv_h_q, conv_t_q, conv_u_q};
        value  <= conv_value;
        err    <= conv_bad_q;
      end
    end
  end

endmodule

// File: tb/tb_seg7_mux_decoder.sv
// Directed self-checking bench for seg7_mux_decoder with STABLE_CYCLES=16.
module tb_seg7_mux_decoder;

`ifdef SEG7_DEC_DEDUP_EN
  localparam int DUP = 0;
`else
  localparam int DUP = 1;
`endif
  localparam int PH = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg_n;
  logic [3:0]  an_n;
  logic [11:0] digits;
  logic [9:0]  value;
  logic        valid;
  logic        err;

  int tests = 0;
  int fails = 0;
  int vcnt  = 0;
  int base;

  always #5 clk = ~clk;

  always @(negedge clk) if (valid === 1'b1) vcnt++;

  seg7_mux_decoder #(.STABLE_CYCLES(16)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .seg_n  (seg_n),
    .an_n   (an_n),
    .digits (digits),
    .value  (value),
    .valid  (valid),
    .err    (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
    an_n  = a;
    seg_n = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic frame(input logic [6:0] h, input logic [6:0] t, input logic [6:0] u);
    hold(4'b1110, u, PH);
    hold(4'b1101, t, PH);
    hold(4'b1011, h, PH);
    hold(4'b1111, 7'h7F, PH);
  endtask

  initial begin
    rst_n = 1'b0;
    an_n  = 4'b1111;
    seg_n = 7'h7F;
    repeat (4) @(negedge clk);
    check("rst_digits", 32'(digits), 32'h0);
    check("rst_value", 32'(value), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    hold(4'b1111, 7'h7F, PH);

    // 2/4/7 frame
    base = vcnt;
    frame(7'h24, 7'h19, 7'h78);
    check("f247_count", 32'(vcnt - base), 32'd1);
    check("f247_digits", 32'(digits), 32'h247);
    check("f247_value", 32'(value), 32'd247);
    check("f247_err", 32'(err), 32'd0);

    // same frame with a short glitch ahead of the tens phase
    base = vcnt;
    hold(4'b1110, 7'h78, PH);
    hold(4'b1101, 7'h00, 3);
    hold(4'b1101, 7'h19, PH);
    hold(4'b1011, 7'h24, PH);
    hold(4'b1111, 7'h7F, PH);
    check("glitch_count", 32'(vcnt - base), 32'(DUP));
    check("glitch_digits", 32'(digits), 32'h247);
    check("glitch_value", 32'(value), 32'd247);

    // blank pattern in the tens slot
    base = vcnt;
    frame(7'h24, 7'h7F, 7'h78);
    check("bad_count", 32'(vcnt - base), 32'd1);
    check("bad_digits", 32'(digits), 32'h2F7);
    check("bad_value", 32'(value), 32'd207);
    check("bad_err", 32'(err), 32'd1);

    // hundreds missing: dropped
    base = vcnt;
    hold(4'b1110, 7'h12, PH);
    hold(4'b1101, 7'h40, PH);
    hold(4'b1111, 7'h7F, PH);
    check("partial_count", 32'(vcnt - base), 32'd0);
    check("partial_hold", 32'(digits), 32'h2F7);

    base = vcnt;
    frame(7'h40, 7'h40, 7'h12);
    check("f005_count", 32'(vcnt - base), 32'd1);
    check("f005_digits", 32'(digits), 32'h005);
    check("f005_value", 32'(value), 32'd5);
    check("f005_err", 32'(err), 32'd0);

    // illegal anode mid-frame discards it
    base = vcnt;
    hold(4'b1110, 7'h78, PH);
    hold(4'b1100, 7'h40, PH);
    hold(4'b1101, 7'h19, PH);
    hold(4'b1011, 7'h24, PH);
    hold(4'b1111, 7'h7F, PH);
    check("anode_count", 32'(vcnt - base), 32'd0);
    check("anode_digits", 32'(digits), 32'h005);

    // 1/2/8 twice
    base = vcnt;
    frame(7'h79, 7'h24, 7'h00);
    check("f128a_count", 32'(vcnt - base), 32'd1);
    check("f128a_digits", 32'(digits), 32'h128);
    check("f128a_value", 32'(value), 32'd128);
    base = vcnt;
    frame(7'h79, 7'h24, 7'h00);
    check("f128b_count", 32'(vcnt - base), 32'(DUP));
    check("f128b_digits", 32'(digits), 32'h128);

    // asynchronous reset in the middle of a frame
    base = vcnt;
    hold(4'b1110, 7'h00, PH);
    hold(4'b1101, 7'h24, PH / 2);
    #2 rst_n = 1'b0;
    #1;
    check("arst_digits", 32'(digits), 32'h0);
    check("arst_value", 32'(value), 32'd0);
    check("arst_err", 32'(err), 32'd0);
    check("arst_valid", 32'(valid), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    hold(4'b1101, 7'h24, PH / 2);
    hold(4'b1011, 7'h79, PH);
    hold(4'b1111, 7'h7F, PH);
    check("arst_count", 32'(vcnt - base), 32'd0);
    check("arst_hold", 32'(digits), 32'h0);

    // first frame after reset reports
    base = vcnt;
    frame(7'h79, 7'h24, 7'h00);
    check("post_count", 32'(vcnt - base), 32'd1);
    check("post_value", 32'(value), 32'd128);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
